// File: rtl/common_types_pkg.sv
// Types shared between the control unit and its downstream execution blocks.
package common_types_pkg;

  typedef logic [63:0] dword_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mult_state_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes and applies the product sign once, when leaving CALC.
module mult_unit
  import common_types_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        half,
  input  logic        signed_a,
  input  logic        signed_b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned ITER = 32 / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(ITER);

  mult_state_t         state_q, state_d;
  dword_t              mcand_q, mcand_d;
  logic [31:0]         mplier_q, mplier_d;
  dword_t              acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                half_q, half_d;
  logic [31:0]         result_q, result_d;

  logic [31:0]         a_mag, b_mag;
  dword_t              partial, acc_sum, prod;

  // 0x80000000 maps to itself, which is the right unsigned magnitude.
  assign a_mag = (signed_a && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_b && b[31]) ? (~b + 32'd1) : b;

  assign partial = mcand_q * {{(64 - BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};
  assign acc_sum = acc_q + partial;
  assign prod    = neg_q ? (~acc_sum + 64'd1) : acc_sum;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    half_d   = half_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          mcand_d  = {32'd0, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = (signed_a & a[31]) ^ (signed_b & b[31]);
          half_d   = half;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ITER - 1)) begin
            // Last digit is folded in here, so the result uses acc_sum, not acc_q.
            result_d = half_q ? prod[63:32] : prod[31:0];
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      half_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      half_q   <= half_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed RV32M cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mult_unit;

  localparam int unsigned BPC  = 2;
  localparam int          ITER = 32 / BPC;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, flush, half, signed_a, signed_b;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 CLK = ~CLK;

  mult_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .half     (half),
    .signed_a (signed_a),
    .signed_b (signed_b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full 64-bit product of the sign/zero-extended operands, then pick a word.
  function automatic logic [31:0] ref_word(input logic [31:0] x, input logic [31:0] y,
                                           input logic h, input logic sx, input logic sy);
    logic [63:0] ex, ey, p;
    ex = sx ? {{32{x[31]}}, x} : {32'd0, x};
    ey = sy ? {{32{y[31]}}, y} : {32'd0, y};
    p  = ex * ey;
    return h ? p[63:32] : p[31:0];
  endfunction

  // Transaction model: age 0 = idle, 1..ITER = computing, ITER+1 = done cycle.
  int          m_age;
  logic [31:0] m_exp, m_result;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_age    <= 0;
      m_exp    <= '0;
      m_result <= '0;
    end else if (m_age == 0) begin
      if (start && !flush) begin
        m_age <= 1;
        m_exp <= ref_word(a, b, half, signed_a, signed_b);
      end
    end else if (flush || m_age == ITER + 1) begin
      m_age <= 0;
    end else if (m_age == ITER) begin
      m_age    <= ITER + 1;
      m_result <= m_exp;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_ready",  64'(ready),  64'(m_age == 0));
      chk("cyc_busy",   64'(busy),   64'(m_age != 0));
      chk("cyc_done",   64'(done),   64'(m_age == ITER + 1));
      chk("cyc_result", 64'(result), 64'(m_result));
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic h, input logic sx, input logic sy);
    a = x; b = y; half = h; signed_a = sx; signed_b = sy; start = 1'b1;
  endtask

  // Called on a falling edge; returns on the falling edge of the idle cycle after done.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic h, input logic sx, input logic sy, input logic [31:0] exp);
    int lat = 0;
    int rdy_low = 0;
    chk({name, "_model"}, 64'(ref_word(x, y, h, sx, sy)), 64'(exp));
    drive(x, y, h, sx, sy);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) start = 1'b0;
      if (!ready) rdy_low++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(ITER + 1));
    chk({name, "_ready_low"}, 64'(rdy_low), 64'(ITER + 1));
    chk({name, "_result"}, 64'(result), 64'(exp));
    @(negedge CLK);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit saw_done;
    int n_done;
    start = 1'b0; flush = 1'b0; a = '0; b = '0;
    half = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    cmp_en = 1'b1;
    @(negedge CLK);
    chk("reset_ready",  64'(ready),  64'd1);
    chk("reset_busy",   64'(busy),   64'd0);
    chk("reset_done",   64'(done),   64'd0);
    chk("reset_result", 64'(result), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    run_op("mul_7x6",    32'd7,          32'd6,          1'b0, 1'b1, 1'b1, 32'h0000_002A);
    run_op("mulh_min",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
    run_op("mul_min",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
    run_op("mulhu_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    run_op("mulh_ff",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    run_op("mul_ff",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_0001);
    run_op("mulhsu_hi",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("mulhsu_lo",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0000_0001);

    // Second start while computing must be ignored.
    lat = 0;
    drive(32'd5, 32'd9, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) start = 1'b0;
      if (k == 3) drive(32'd100, 32'd100, 1'b0, 1'b0, 1'b0);
      if (k == 4) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ignore_latency", 64'(lat), 64'(ITER + 1));
    chk("ignore_result", 64'(result), 64'd45);
    @(negedge CLK);

    // Flush during cycle 5: idle in cycle 6, no done, result keeps 45.
    saw_done = 1'b0;
    drive(32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_done", 64'(done | saw_done), 64'd0);
    chk("flush_result", 64'(result), 64'd45);
    run_op("after_flush", 32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 32'd143);

    // Asynchronous reset in the middle of cycle 8.
    drive(32'd123, 32'd456, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      if (k == 1) start = 1'b0;
    end
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_ready",  64'(ready),  64'd1);
    chk("async_rst_busy",   64'(busy),   64'd0);
    chk("async_rst_done",   64'(done),   64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 64'(ready), 64'd1);
    run_op("post_rst_3x4", 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'h0000_000C);

    // Random traffic including stray starts and flushes; checked by the compare process.
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (done) n_done++;
      start    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(23) == 0);
      a        = pick();
      b        = pick();
      half     = 1'($urandom_range(1));
      signed_a = 1'($urandom_range(1));
      signed_b = 1'($urandom_range(1));
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (ITER + 4) @(negedge CLK);
    chk("random_done_count", 64'(n_done > 20), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
